// File: rtl/ctz_seq.sv
// Multi-cycle count-trailing-zeros unit: scans STEP bits per cycle from the LSB with early exit.
// Optional CTZ_CTO_EN: with ones=1 at start, the operand is inverted so trailing ones are counted.
module ctz_seq #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] ctz_in,
   input  logic             ones,
   output logic             busy,
   output logic             done,
   output logic [31:0]      ctz_out
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] sr_r;
   logic [WIDTH-1:0] sr_s;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_s;
   logic [31:0]      ctz_out_r;
   logic [31:0]      ctz_out_s;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] operand_s;

   // Index of the lowest set bit in a STEP group; the group is known non-zero when used.
   function automatic logic [CW-1:0] low_set_idx(input logic [STEP-1:0] grp);
      logic [CW-1:0] idx;
      idx = {CW{1'b0}};
      for (int i = STEP - 1; i >= 0; i--) begin
         if (grp[i]) begin
            idx = CW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

`ifdef CTZ_CTO_EN
   // Operand to latch: inverted when counting trailing ones.
   always_comb begin
      operand_s = ctz_in;
      if (ones) begin
         operand_s = ~ctz_in;
      end else begin
         operand_s = ctz_in;
      end
   end
`else
   logic ones_unused;
   assign ones_unused = ones;

   // Operand to latch: trailing-zero mode only.
   always_comb begin
      operand_s = ctz_in;
   end
`endif

   // Next-state, shift register, counter and result computation.
   always_comb begin
      state_s   = state_r;
      sr_s      = sr_r;
      cnt_s     = cnt_r;
      ctz_out_s = ctz_out_r;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               sr_s    = operand_s;
               cnt_s   = {CW{1'b0}};
               state_s = SCAN;
            end else begin
               state_s = IDLE;
            end
         end
         SCAN: begin
            if (sr_r == {WIDTH{1'b0}}) begin
               ctz_out_s = 32'(WIDTH);
               state_s   = DONE;
            end else if (sr_r[STEP-1:0] != {STEP{1'b0}}) begin
               ctz_out_s = 32'(cnt_r + low_set_idx(sr_r[STEP-1:0]));
               state_s   = DONE;
            end else begin
               sr_s    = sr_r >> STEP;
               cnt_s   = cnt_r + CW'(STEP);
               state_s = SCAN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers; busy/done are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         sr_r      <= {WIDTH{1'b0}};
         cnt_r     <= {CW{1'b0}};
         ctz_out_r <= 32'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         sr_r      <= sr_s;
         cnt_r     <= cnt_s;
         ctz_out_r <= ctz_out_s;
         busy_r    <= (state_s == SCAN);
         done_r    <= (state_s == DONE);
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign ctz_out = ctz_out_r;

endmodule

// File: doc/ctz_seq.md
Name: ctz_seq

Overview:
- Multi-cycle count-trailing-zeros unit. It scans the operand from the LSB end, the opposite direction to the CPU's combinational leading-zero counter.
- Used by the ALU/multi-cycle execute path for find-first-set and bit-scan style operations.
- Handshake: start/busy/done. The operand is consumed STEP bits per cycle, with early exit.
- Result is a 32-bit zero-extended count, in the same format as the leading-zero count.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of STEP.
- STEP, 4, bits examined per SCAN cycle. Legal values: 1, 2, 4, 8.

Ports:
- clk, input, 1, clock. All state updates on the rising edge.
- rst, input, 1, reset, synchronous and active-high.
- start, input, 1, request. Sampled only in IDLE or DONE.
- ctz_in, input, WIDTH, operand. Sampled on the start edge only.
- ones, input, 1, count trailing ones instead of zeros. Honoured only with CTZ_CTO_EN.
- busy, output, 1, high while in SCAN.
- done, output, 1, one-cycle pulse when the result becomes valid.
- ctz_out, output, 32, trailing-zero count, 0..WIDTH, zero-extended.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0; done=0; ctz_out=0; internal shift register and counter cleared.
  - Applies from any state, including mid-SCAN. The in-flight operation is discarded and no done is issued.
- States: IDLE, SCAN, DONE.
- IDLE: busy=0, done=0.
  - start=1: latch ctz_in into the shift register sr, clear counter cnt=0, go to SCAN.
- SCAN: busy=1, done=0. Each cycle:
  - sr==0: result=WIDTH, go to DONE.
  - Otherwise, if sr[STEP-1:0]!=0: result = cnt + index of the lowest set bit in sr[STEP-1:0], go to DONE.
  - Otherwise: sr = sr >> STEP (zero fill), cnt += STEP, stay in SCAN.
  - start is ignored in SCAN. No queueing.
- DONE: done=1 for exactly this cycle; busy=0; ctz_out = result.
  - start=1: accept a new operand, go straight to SCAN (back-to-back).
  - start=0: go to IDLE.
- ctz_out is registered. It updates only on entry to DONE and holds until the next DONE or reset.
- Latency is counted in edges from the start edge to the first cycle done is high:
  - tz < WIDTH: floor(tz/STEP) + 2 edges.
  - ctz_in==0: 2 edges, via the early exit.
  - Worst case: WIDTH/STEP + 1 edges (tz = WIDTH-1).
- Width rules:
  - cnt is wide enough to hold WIDTH.
  - ctz_out = {zeros, result}.
  - The index within a STEP group is a priority encode from bit 0 upward.

Optional Feature:
- Macro: CTZ_CTO_EN.
- Defined: when start is accepted with ones=1, sr latches ~ctz_in, so the block counts trailing ones.
  - All-ones operand → ctz_out=WIDTH, 2-edge latency.
  - ones is sampled only on the start edge.
- Undefined: ones is ignored (input present, unconnected internally); always counts trailing zeros.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → busy=0, done=0, ctz_out=0; remain quiet with start=0.
- ctz_in=0x00000001, start pulse → done high 2 edges later, ctz_out=0, busy high for 1 cycle.
- ctz_in=0x80000000 → 8 SCAN cycles (STEP=4), done 9 edges after start, ctz_out=31.
- ctz_in=0x00000000 → early exit, done 2 edges after start, ctz_out=32.
- ctz_in=0x00000100, then start held high in the DONE cycle with ctz_in=0x00000008:
  - First result ctz_out=8.
  - Second op enters SCAN immediately, giving ctz_out=3.
  - A start asserted mid-SCAN is ignored.
- Reset mid-SCAN, and CTZ_CTO_EN:
  - Reset mid-SCAN: start 0x80000000, rst=1 on the 4th SCAN cycle → IDLE, no done, ctz_out=0.
  - With CTZ_CTO_EN defined, ones=1 and ctz_in=0x0000000F → ctz_out=4.
